md_scheduler: RTL and testbench
===============================

Name: md_scheduler

Overview:
Controller for the shared multiply/divide resource beside the execute-stage ALU.
- Accepts one MULT/MULTU/DIV/DIVU request at a time from decode through a valid/ready handshake.
- Launches the mul or div unit, waits for its completion pulse and commits the 64-bit result into architectural HI/LO.
- Raises hilo_busy so the hazard unit stalls MFHI/MFLO and further MD issues.
- Also services MTHI/MTLO writes and pipeline-flush cancellation.

Parameters:
- WDOG_CYCLES, 40: maximum cycles allowed in WAIT before md_err is set; must exceed the div unit latency.
- CNT_W, 6: width of the watchdog counter; must satisfy 2^CNT_W > WDOG_CYCLES.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- issue_valid  in  1  decode presents an MD op
- issue_ready  out  1  scheduler can accept
- issue_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- issue_src1  in  32  rs value
- issue_src2  in  32  rt value
- cancel  in  1  flush of the in-flight MD op
- mthi_en  in  1  MTHI write
- mtlo_en  in  1  MTLO write
- mt_data  in  32  MTHI/MTLO data
- mul_en  out  1  one-cycle launch pulse to the mul unit
- div_en  out  1  one-cycle launch pulse to the div unit
- md_signed  out  1  signed operation
- md_x  out  32  operand 1, registered
- md_y  out  32  operand 2, registered
- mul_complete  in  1  mul unit done pulse
- mul_result  in  64  {hi,lo}
- div_complete  in  1  div unit done pulse
- quotient  in  32  div quotient
- remainder  in  32  div remainder
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO
- hilo_busy  out  1  MD op outstanding
- md_err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn, sampled on the rising edge of clk.
- Reset values:
  - State IDLE.
  - hi_out, lo_out, md_x, md_y are 0.
  - mul_en, div_en, md_signed, hilo_busy, md_err are 0.
  - issue_ready is 1 in the first cycle after reset.
  - Reset mid-operation abandons the op; HI/LO are not written.
- States: IDLE, LAUNCH, WAIT, DRAIN.
- IDLE:
  - issue_ready=1.
  - On issue_valid: latch src1/src2 into md_x/md_y, latch md_signed=~issue_op[0] and is_div=issue_op[1]; go to LAUNCH.
- LAUNCH (exactly one cycle):
  - mul_en=~is_div, div_en=is_div.
  - Go to WAIT, or to DRAIN if cancel=1 this cycle.
- WAIT:
  - The selected unit's complete pulse commits on the same edge: HI=mul_result[63:32] or remainder; LO=mul_result[31:0] or quotient.
  - Then go to IDLE.
  - The complete pulse of the non-selected unit is ignored.
- DRAIN:
  - Entered on cancel in LAUNCH or WAIT.
  - Wait for the selected unit's complete pulse, discard the result, then go to IDLE. Units cannot be aborted.
  - cancel in IDLE is a no-op.
- hilo_busy = (state != IDLE); issue_ready = (state == IDLE).
- Latency: accept at edge N, launch pulse in cycle N+1, commit on the complete edge; hilo_busy is low the cycle after commit.
- Watchdog:
  - The counter clears on entry to LAUNCH and counts in WAIT/DRAIN.
  - Reaching WDOG_CYCLES sets md_err (sticky until reset) and forces IDLE without writing.
- MTHI/MTLO:
  - Write HI/LO in any state.
  - If an MT write and a result commit hit the same edge, the MT half wins; the other half takes the result.
  - mthi_en and mtlo_en may both be set.
- Outputs: hi_out/lo_out are registered; no bypass of the commit value.

Optional Feature:
- Macro: MD_DIV0_BYPASS_EN.
- Defined: a DIV/DIVU accepted with issue_src2==0 skips the unit.
  - div_en is not pulsed.
  - LAUNCH commits directly: HI=src1, LO=32'hFFFFFFFF.
  - Returns to IDLE after the single LAUNCH cycle (busy for one cycle).
- Undefined: divide-by-zero is launched to the div unit like any division.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encodings
  - DIV0_LO constant 32'hFFFFFFFF
- Sub-module md_watchdog (counter + sticky error, parameters WDOG_CYCLES, CNT_W) is natural; the FSM stays in md_scheduler.

Test Plan:
- MULT with src1=32'hFFFFFFFE (-2), src2=3, model completes 2 cycles after mul_en -> mul_en one pulse with md_signed=1; HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; hilo_busy high 4 cycles.
- DIVU with src1=100, src2=7, model completes 33 cycles after div_en -> LO=14, HI=2; issue_ready low throughout; second issue_valid held high is accepted only after commit.
- Cancel in WAIT for MULTU 5*6 with HI/LO preset to 0x11/0x22 -> busy until mul_complete, HI/LO remain 0x11/0x22, back in IDLE.
- MTLO data 0xABCD on the same edge as the MULT 2*3 commit -> LO=0xABCD, HI=0.
- Div model never completes, WDOG_CYCLES=40 -> md_err=1 after 40 WAIT cycles, IDLE, HI/LO unchanged; resetn low clears md_err.
- With MD_DIV0_BYPASS_EN, DIV 9/0 -> no div_en, HI=9, LO=32'hFFFFFFFF, busy one cycle. Without the macro -> div_en pulses.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op and state encodings
// and the constant LO value produced by the divide-by-zero bypass.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10,
        ST_DRAIN  = 2'b11
    } md_state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter that bounds how long the scheduler waits on a unit; raises a
// one-cycle expire strobe and a sticky error flag.
module md_watchdog #(
    parameter int WDOG_CYCLES = 40,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic expire,
    output logic err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Expiry fires during the WDOG_CYCLES-th counted cycle, so the scheduler
    // leaves on that same edge.
    assign expire = run && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide issue scheduler and architectural HI/LO owner.
// Optional macro MD_DIV0_BYPASS_EN: divide-by-zero commits directly from LAUNCH.
module md_scheduler
    import md_pkg::*;
#(
    parameter int WDOG_CYCLES = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_op,
    input  logic [31:0] issue_src1,
    input  logic [31:0] issue_src2,
    input  logic        cancel,
    input  logic        mthi_en,
    input  logic        mtlo_en,
    input  logic [31:0] mt_data,
    output logic        mul_en,
    output logic        div_en,
    output logic        md_signed,
    output logic [31:0] md_x,
    output logic [31:0] md_y,
    input  logic        mul_complete,
    input  logic [63:0] mul_result,
    input  logic        div_complete,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hilo_busy,
    output logic        md_err
);

    md_state_e   state, next_state;
    logic        is_div;
    logic        div0;
    logic        accept;
    logic        sel_complete;
    logic [31:0] res_hi, res_lo;
    logic        commit;
    logic [31:0] commit_hi, commit_lo;
    logic        wd_run, wd_expire;

    assign accept       = (state == ST_IDLE) && issue_valid;
    assign issue_ready  = (state == ST_IDLE);
    assign hilo_busy    = (state != ST_IDLE);

    // Only the unit this op was launched on may complete it.
    assign sel_complete = is_div ? div_complete : mul_complete;
    assign res_hi       = is_div ? remainder : mul_result[63:32];
    assign res_lo       = is_div ? quotient  : mul_result[31:0];

    assign wd_run = ((state == ST_WAIT) || (state == ST_DRAIN)) && !sel_complete;

    md_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (accept),
        .run    (wd_run),
        .expire (wd_expire),
        .err    (md_err)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        commit_hi  = res_hi;
        commit_lo  = res_lo;
        mul_en     = 1'b0;
        div_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue_valid) next_state = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (div0) begin
                    commit     = !cancel;
                    commit_hi  = md_x;
                    commit_lo  = DIV0_LO;
                    next_state = ST_IDLE;
                end else begin
                    mul_en     = !is_div;
                    div_en     = is_div;
                    next_state = cancel ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A cancel racing the completion discards the result; the unit
                // is already done, so there is nothing left to drain.
                if (sel_complete) begin
                    commit     = !cancel;
                    next_state = ST_IDLE;
                end else if (wd_expire) begin
                    next_state = ST_IDLE;
                end else if (cancel) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sel_complete || wd_expire) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            md_x      <= '0;
            md_y      <= '0;
            md_signed <= 1'b0;
            is_div    <= 1'b0;
        end else if (accept) begin
            md_x      <= issue_src1;
            md_y      <= issue_src2;
            md_signed <= ~issue_op[0];
            is_div    <= issue_op[1];
        end
    end

`ifdef MD_DIV0_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div0 <= 1'b0;
        end else if (accept) begin
            div0 <= issue_op[1] && (issue_src2 == '0);
        end
    end
`else
    assign div0 = 1'b0;
`endif

    // MT writes own their half of HI/LO over a coincident result commit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            if (mthi_en) begin
                hi_out <= mt_data;
            end else if (commit) begin
                hi_out <= commit_hi;
            end
            if (mtlo_en) begin
                lo_out <= mt_data;
            end else if (commit) begin
                lo_out <= commit_lo;
            end
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: behavioural mul/div unit stubs plus an
// arithmetic reference for HI/LO, busy duration and launch pulses.
module tb_md_scheduler;
    import md_pkg::*;

    localparam int WDOG = 40;
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [1:0]  issue_op = 2'b00;
    logic [31:0] issue_src1 = '0;
    logic [31:0] issue_src2 = '0;
    logic        cancel = 1'b0;
    logic        mthi_en = 1'b0;
    logic        mtlo_en = 1'b0;
    logic [31:0] mt_data = '0;
    logic        mul_en, div_en, md_signed;
    logic [31:0] md_x, md_y;
    logic        mul_complete = 1'b0;
    logic [63:0] mul_result = '0;
    logic        div_complete = 1'b0;
    logic [31:0] quotient = '0;
    logic [31:0] remainder = '0;
    logic [31:0] hi_out, lo_out;
    logic        hilo_busy, md_err;

    int n_cmp = 0;
    int n_bad = 0;

    md_scheduler #(.WDOG_CYCLES(WDOG), .CNT_W(6)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_op     (issue_op),
        .issue_src1   (issue_src1),
        .issue_src2   (issue_src2),
        .cancel       (cancel),
        .mthi_en      (mthi_en),
        .mtlo_en      (mtlo_en),
        .mt_data      (mt_data),
        .mul_en       (mul_en),
        .div_en       (div_en),
        .md_signed    (md_signed),
        .md_x         (md_x),
        .md_y         (md_y),
        .mul_complete (mul_complete),
        .mul_result   (mul_result),
        .div_complete (div_complete),
        .quotient     (quotient),
        .remainder    (remainder),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .hilo_busy    (hilo_busy),
        .md_err       (md_err)
    );

    always #5 clk = ~clk;

    // Reference result {HI, LO} of an MD op from plain arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint sp;
        longint unsigned up;
        sa = a;
        sb = b;
        ref_md = '0;
        case (op)
            MD_MULT: begin
                sp = longint'(sa) * longint'(sb);
                ref_md = sp;
            end
            MD_MULTU: begin
                up = {32'b0, a};
                up = up * {32'b0, b};
                ref_md = up;
            end
            default: begin
                if (b == 0)            ref_md = {a, 32'hFFFF_FFFF};
                else if (op == MD_DIV) ref_md = {32'(sa % sb), 32'(sa / sb)};
                else                   ref_md = {a % b, a / b};
            end
        endcase
    endfunction

    // Unit stubs: complete pulses in cycle L+delay+1 for a launch in cycle L.
    int mul_delay = 2, div_delay = 33;
    bit div_never = 1'b0;
    int mul_left = 0, div_left = 0;
    int mul_pulses = 0, div_pulses = 0;

    always @(negedge clk) begin
        mul_complete = 1'b0;
        div_complete = 1'b0;
        if (!resetn) begin
            mul_left = 0;
            div_left = 0;
        end else begin
            if (mul_en === 1'b1) begin
                mul_pulses++;
                mul_left = mul_delay + 1;
                mul_result = ref_md(md_signed ? MD_MULT : MD_MULTU, md_x, md_y);
            end else if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) mul_complete = 1'b1;
            end
            if (div_en === 1'b1) begin
                div_pulses++;
                if (!div_never) div_left = div_delay + 1;
                {remainder, quotient} = ref_md(md_signed ? MD_DIV : MD_DIVU, md_x, md_y);
            end else if (div_left > 0) begin
                div_left--;
                if (div_left == 0) div_complete = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_src1  = a;
        issue_src2  = b;
        tick();
        issue_valid = 1'b0;
    endtask

    // Counts busy cycles starting with the current one.
    task automatic wait_idle(output int n, output bit expired);
        n = 0;
        while (hilo_busy === 1'b1 && n < BOUND) begin
            n++;
            tick();
        end
        expired = (n >= BOUND);
    endtask

    task automatic test_reset();
        int n;
        bit to;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        n_cmp++;
        if ({hi_out, lo_out, md_x, md_y} !== 128'b0) begin
            $display("FAIL reset_data: hi=%h lo=%h x=%h y=%h, want all 0", hi_out, lo_out, md_x, md_y);
            n_bad++;
        end
        n_cmp++;
        if ({issue_ready, hilo_busy, md_err, mul_en, div_en, md_signed} !== 6'b100000) begin
            $display("FAIL reset_ctrl: rdy/busy/err/mul/div/sgn=%b want 100000",
                     {issue_ready, hilo_busy, md_err, mul_en, div_en, md_signed});
            n_bad++;
        end
        mul_delay = 2;
        issue(MD_MULT, 32'd7, 32'd9);
        tick();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if ({hilo_busy, issue_ready, hi_out, lo_out} !== {1'b0, 1'b1, 64'b0}) begin
            $display("FAIL reset_midop: busy=%b rdy=%b hi=%h lo=%h, want 0 1 0 0", hilo_busy, issue_ready, hi_out, lo_out);
            n_bad++;
        end
    endtask

    task automatic test_mult_basic();
        int n, p0;
        bit to;
        mul_delay = 2;
        p0 = mul_pulses;
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        n_cmp++;
        if ({mul_en, div_en, md_signed} !== 3'b101 || md_x !== 32'hFFFF_FFFE || md_y !== 32'd3) begin
            $display("FAIL mult_launch: mul/div/sgn=%b x=%h y=%h, want 101 fffffffe 3",
                     {mul_en, div_en, md_signed}, md_x, md_y);
            n_bad++;
        end
        wait_idle(n, to);
        n_cmp++;
        if (to || n != 4) begin
            $display("FAIL mult_busy: busy cycles=%0d timeout=%0d, want 4", n, to);
            n_bad++;
        end
        n_cmp++;
        if (mul_pulses - p0 != 1) begin
            $display("FAIL mult_pulses: got %0d, want 1", mul_pulses - p0);
            n_bad++;
        end
        n_cmp++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA) begin
            $display("FAIL mult_result: hi=%h lo=%h, want ffffffff fffffffa", hi_out, lo_out);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int n, p0;
        bit to, ready_seen;
        div_delay = 33;
        p0 = div_pulses;
        issue_valid = 1'b1;
        issue_op    = MD_DIVU;
        issue_src1  = 32'd100;
        issue_src2  = 32'd7;
        tick();
        issue_src1 = 32'd50;
        issue_src2 = 32'd8;
        n = 0;
        ready_seen = 1'b0;
        while (hilo_busy === 1'b1 && n < BOUND) begin
            if (issue_ready !== 1'b0) ready_seen = 1'b1;
            n++;
            tick();
        end
        n_cmp++;
        if (n != 35 || ready_seen) begin
            $display("FAIL divu_busy: busy cycles=%0d ready_while_busy=%0d, want 35 0", n, ready_seen);
            n_bad++;
        end
        n_cmp++;
        if (hi_out !== 32'd2 || lo_out !== 32'd14 || issue_ready !== 1'b1) begin
            $display("FAIL divu_result: hi=%0d lo=%0d rdy=%b, want 2 14 1", hi_out, lo_out, issue_ready);
            n_bad++;
        end
        tick();
        issue_valid = 1'b0;
        n_cmp++;
        if (div_en !== 1'b1 || md_x !== 32'd50 || md_y !== 32'd8) begin
            $display("FAIL divu_second_accept: div_en=%b x=%0d y=%0d, want 1 50 8", div_en, md_x, md_y);
            n_bad++;
        end
        wait_idle(n, to);
        n_cmp++;
        if (to || hi_out !== 32'd2 || lo_out !== 32'd6 || div_pulses - p0 != 2) begin
            $display("FAIL divu_second_result: hi=%0d lo=%0d pulses=%0d to=%0d, want 2 6 2 0",
                     hi_out, lo_out, div_pulses - p0, to);
            n_bad++;
        end
    endtask

    task automatic test_cancel_wait();
        int n;
        bit to;
        mthi_en = 1'b1; mt_data = 32'h11; tick(); mthi_en = 1'b0;
        mtlo_en = 1'b1; mt_data = 32'h22; tick(); mtlo_en = 1'b0;
        mul_delay = 4;
        issue(MD_MULTU, 32'd5, 32'd6);
        tick();
        n_cmp++;
        if ({mul_en, hilo_busy, md_signed} !== 3'b010) begin
            $display("FAIL cancel_in_wait: mul/busy/sgn=%b, want 010", {mul_en, hilo_busy, md_signed});
            n_bad++;
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_idle(n, to);
        n_cmp++;
        if (to || n != 4) begin
            $display("FAIL cancel_drain: drain cycles=%0d to=%0d, want 4", n, to);
            n_bad++;
        end
        n_cmp++;
        if (hi_out !== 32'h11 || lo_out !== 32'h22 || issue_ready !== 1'b1) begin
            $display("FAIL cancel_hilo: hi=%h lo=%h rdy=%b, want 11 22 1", hi_out, lo_out, issue_ready);
            n_bad++;
        end
    endtask

    task automatic test_mt_collision();
        int n;
        mul_delay = 3;
        issue(MD_MULT, 32'd2, 32'd3);
        n = 0;
        while (mul_complete !== 1'b1 && n < BOUND) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n >= BOUND) begin
            $display("FAIL mt_wait_complete: no mul_complete within %0d cycles", BOUND);
            n_bad++;
        end
        mtlo_en = 1'b1;
        mt_data = 32'hABCD;
        tick();
        mtlo_en = 1'b0;
        n_cmp++;
        if (hi_out !== 32'h0 || lo_out !== 32'hABCD || hilo_busy !== 1'b0) begin
            $display("FAIL mt_collision: hi=%h lo=%h busy=%b, want 0 abcd 0", hi_out, lo_out, hilo_busy);
            n_bad++;
        end
    endtask

    task automatic test_watchdog();
        int n;
        bit to;
        div_never = 1'b1;
        issue(MD_DIV, 32'd7, 32'd2);
        wait_idle(n, to);
        n_cmp++;
        if (to || n != WDOG + 1) begin
            $display("FAIL wdog_busy: busy cycles=%0d to=%0d, want %0d", n, to, WDOG + 1);
            n_bad++;
        end
        repeat (3) tick();
        n_cmp++;
        if (md_err !== 1'b1 || issue_ready !== 1'b1 || hi_out !== 32'h0 || lo_out !== 32'hABCD) begin
            $display("FAIL wdog_err: err=%b rdy=%b hi=%h lo=%h, want 1 1 0 abcd", md_err, issue_ready, hi_out, lo_out);
            n_bad++;
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        div_never = 1'b0;
        n_cmp++;
        if (md_err !== 1'b0 || lo_out !== 32'h0) begin
            $display("FAIL wdog_reset: err=%b lo=%h, want 0 0", md_err, lo_out);
            n_bad++;
        end
    endtask

    task automatic test_div0();
        int n, p0, exp_busy;
        bit to;
        logic exp_div_en;
`ifdef MD_DIV0_BYPASS_EN
        exp_div_en = 1'b0;
        exp_busy   = 1;
`else
        exp_div_en = 1'b1;
        exp_busy   = 7;
`endif
        div_delay = 5;
        p0 = div_pulses;
        issue(MD_DIV, 32'd9, 32'd0);
        n_cmp++;
        if (div_en !== exp_div_en || mul_en !== 1'b0) begin
            $display("FAIL div0_launch: div_en=%b mul_en=%b, want %b 0", div_en, mul_en, exp_div_en);
            n_bad++;
        end
        wait_idle(n, to);
        n_cmp++;
        if (to || n != exp_busy || div_pulses - p0 != int'(exp_div_en)) begin
            $display("FAIL div0_busy: busy=%0d pulses=%0d, want %0d %0d", n, div_pulses - p0, exp_busy, exp_div_en);
            n_bad++;
        end
        n_cmp++;
        if (hi_out !== 32'd9 || lo_out !== DIV0_LO) begin
            $display("FAIL div0_result: hi=%h lo=%h, want 9 ffffffff", hi_out, lo_out);
            n_bad++;
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_hi, ref_lo, a, b, mt_val;
        logic [63:0] r;
        logic [1:0]  op, mt_sel;
        bit          cancel_it, to;
        int          n, delay;
        ref_hi = $urandom;
        ref_lo = $urandom;
        mthi_en = 1'b1; mt_data = ref_hi; tick(); mthi_en = 1'b0;
        mtlo_en = 1'b1; mt_data = ref_lo; tick(); mtlo_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            op        = 2'($urandom_range(0, 3));
            a         = $urandom;
            b         = $urandom;
            if (b == 0 || b == 32'hFFFF_FFFF) b = 32'd3;
            mul_delay = $urandom_range(0, 6);
            div_delay = $urandom_range(1, 30);
            delay     = op[1] ? div_delay : mul_delay;
            cancel_it = ($urandom_range(0, 3) == 0);
            mt_sel    = 2'($urandom_range(0, 3));
            mt_val    = $urandom;
            issue(op, a, b);
            n_cmp++;
            if (md_signed !== ~op[0] || {mul_en, div_en} !== {~op[1], op[1]}) begin
                $display("FAIL rand_launch[%0d]: op=%0d sgn=%b mul=%b div=%b", i, op, md_signed, mul_en, div_en);
                n_bad++;
            end
            mthi_en = mt_sel[0];
            mtlo_en = mt_sel[1];
            mt_data = mt_val;
            cancel  = cancel_it;
            tick();
            {mthi_en, mtlo_en, cancel} = 3'b000;
            if (mt_sel[0]) ref_hi = mt_val;
            if (mt_sel[1]) ref_lo = mt_val;
            wait_idle(n, to);
            n_cmp++;
            if (to || n + 1 != delay + 2) begin
                $display("FAIL rand_busy[%0d]: busy=%0d want %0d", i, n + 1, delay + 2);
                n_bad++;
            end
            if (!cancel_it) begin
                r = ref_md(op, a, b);
                ref_hi = r[63:32];
                ref_lo = r[31:0];
            end
            n_cmp++;
            if (hi_out !== ref_hi || lo_out !== ref_lo) begin
                $display("FAIL rand_hilo[%0d]: op=%0d a=%h b=%h cancel=%0d hi=%h lo=%h, want %h %h",
                         i, op, a, b, cancel_it, hi_out, lo_out, ref_hi, ref_lo);
                n_bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_back_to_back();
        test_cancel_wait();
        test_mt_collision();
        test_watchdog();
        test_div0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
